// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap-entry / trap-return sequencer.
// Holds the FSM state encoding, CSR select codes and mstatus/mcause field layout.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT,
        ST_RET_REDIRECT
    } trap_state_e;

    localparam logic [1:0] CSR_SEL_MSTATUS = 2'd0;
    localparam logic [1:0] CSR_SEL_MEPC    = 2'd1;
    localparam logic [1:0] CSR_SEL_MCAUSE  = 2'd2;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam int MCAUSE_CODE_W = 5;
    localparam int MCAUSE_PAD_W  = 26;

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle between decode/fetch and the trap sequencer: trap requests, CSR writes,
// redirect handshake and the CSR values fed back to decode.
interface trap_sequencer_if;
    logic        interrupt;
    logic        exception;
    logic [4:0]  int_code;
    logic [31:0] handler_pc;
    logic [31:0] epc;
    logic        mret;
    logic        redirect_ready;
    logic        csr_we;
    logic [1:0]  csr_sel;
    logic [31:0] csr_wdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_active;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        mstatus_mie;
    logic        mstatus_mpie;

    modport slave (
        input  interrupt, exception, int_code, handler_pc, epc, mret,
               redirect_ready, csr_we, csr_sel, csr_wdata,
        output flush, redirect_valid, redirect_pc, trap_active,
               mepc, mcause, mstatus_mie, mstatus_mpie
    );

    modport master (
        output interrupt, exception, int_code, handler_pc, epc, mret,
               redirect_ready, csr_we, csr_sel, csr_wdata,
        input  flush, redirect_valid, redirect_pc, trap_active,
               mepc, mcause, mstatus_mie, mstatus_mpie
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: trap -> DRAIN_CYCLES of flush, 1 commit cycle, then redirect
// (CSRs visible with redirect); mret redirects next cycle. Redirect held until redirect_ready.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    trap_sequencer_if.slave  bus
);

    trap_state_e              state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [31:0]              epc_q, epc_d;
    logic [MCAUSE_CODE_W-1:0] code_q, code_d;
    logic                     is_intr_q, is_intr_d;
    logic [31:0]              mepc_q, mepc_d;
    logic                     mc_intr_q, mc_intr_d;
    logic [MCAUSE_CODE_W-1:0] mc_code_q, mc_code_d;
    logic                     mie_q, mie_d;
    logic                     mpie_q, mpie_d;
    logic                     ret_first_q, ret_first_d;
    logic                     trap_active_q, trap_active_d;

    logic unused_bits;
    assign unused_bits = ^{bus.epc[1:0], bus.csr_wdata[30:8], bus.csr_wdata[6:5]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        epc_d       = epc_q;
        code_d      = code_q;
        is_intr_d   = is_intr_q;
        mepc_d      = mepc_q;
        mc_intr_d   = mc_intr_q;
        mc_code_d   = mc_code_q;
        mie_d       = mie_q;
        mpie_d      = mpie_q;
        ret_first_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // exception outranks interrupt, and either trap swallows a same-cycle mret
                if (bus.exception || bus.interrupt) begin
                    epc_d     = {bus.epc[31:2], 2'b00};
                    code_d    = bus.int_code;
                    is_intr_d = !bus.exception;
                    cnt_d     = 4'(DRAIN_CYCLES);
                    state_d   = ST_DRAIN;
                end else if (bus.mret) begin
                    mie_d       = mpie_q;
                    mpie_d      = 1'b1;
                    ret_first_d = 1'b1;
                    state_d     = ST_RET_REDIRECT;
                end else if (bus.csr_we) begin
                    case (bus.csr_sel)
                        CSR_SEL_MSTATUS: begin
                            mie_d  = bus.csr_wdata[MSTATUS_MIE_BIT];
                            mpie_d = bus.csr_wdata[MSTATUS_MPIE_BIT];
                        end
                        CSR_SEL_MEPC:   mepc_d = {bus.csr_wdata[31:2], 2'b00};
                        CSR_SEL_MCAUSE: begin
                            mc_intr_d = bus.csr_wdata[31];
                            mc_code_d = bus.csr_wdata[MCAUSE_CODE_W-1:0];
                        end
                        default: ;
                    endcase
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                mepc_d    = epc_q;
                mc_intr_d = is_intr_q;
                mc_code_d = code_q;
                mpie_d    = mie_q;
                mie_d     = 1'b0;
                state_d   = ST_REDIRECT;
            end
            ST_REDIRECT,
            ST_RET_REDIRECT: begin
                if (bus.redirect_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        trap_active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            epc_q         <= '0;
            code_q        <= '0;
            is_intr_q     <= 1'b0;
            mepc_q        <= RESET_PC;
            mc_intr_q     <= 1'b0;
            mc_code_q     <= '0;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            ret_first_q   <= 1'b0;
            trap_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            epc_q         <= epc_d;
            code_q        <= code_d;
            is_intr_q     <= is_intr_d;
            mepc_q        <= mepc_d;
            mc_intr_q     <= mc_intr_d;
            mc_code_q     <= mc_code_d;
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            ret_first_q   <= ret_first_d;
            trap_active_q <= trap_active_d;
        end
    end

    // handler_pc passes straight through so vectored decode sees the freshly committed mcause
    assign bus.flush          = (state_q == ST_DRAIN) || (state_q == ST_COMMIT) ||
                                ((state_q == ST_RET_REDIRECT) && ret_first_q);
    assign bus.redirect_valid = (state_q == ST_REDIRECT) || (state_q == ST_RET_REDIRECT);
    assign bus.redirect_pc    = (state_q == ST_REDIRECT)     ? bus.handler_pc :
                                (state_q == ST_RET_REDIRECT) ? mepc_q : 32'h0;
    assign bus.trap_active    = trap_active_q;
    assign bus.mepc           = mepc_q;
    assign bus.mcause         = {mc_intr_q, {MCAUSE_PAD_W{1'b0}}, mc_code_q};
    assign bus.mstatus_mie    = mie_q;
    assign bus.mstatus_mpie   = mpie_q;

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequential trap-entry and trap-return controller that sits directly downstream of the interrupt/exception decode logic in the CSR datapath. It samples the combinational `interrupt`, `exception`, cause code and handler address, flushes and drains the pipeline, and commits `mepc`, `mcause` and `mstatus.MIE/MPIE`. It then issues a single PC redirect to the handler, or to `mepc` on `mret`. It owns these three CSRs and feeds `mcause` and `MIE` back to the decode logic.

## Interface
- `DRAIN_CYCLES`, 2: cycles `flush` is held before commit (1..15)
- `RESET_PC`, 32'h0: reset value of `mepc`

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `interrupt`  in  1  enabled interrupt pending (already gated by MIE)
- `exception`  in  1  synchronous exception in current instruction
- `int_code`  in  5  cause code from decode
- `handler_pc`  in  32  trap vector address; depends on current `mcause` in vectored mode
- `epc`  in  32  PC of the faulting or interrupted instruction
- `mret`  in  1  mret retiring this cycle
- `redirect_ready`  in  1  fetch accepts redirect
- `csr_we`  in  1  software CSR write strobe
- `csr_sel`  in  2  0=mstatus, 1=mepc, 2=mcause, 3=none
- `csr_wdata`  in  32  write data
- `flush`  out  1  kill in-flight instructions
- `redirect_valid`  out  1  redirect request
- `redirect_pc`  out  32  redirect target
- `trap_active`  out  1  FSM not IDLE
- `mepc`  out  32  mepc CSR
- `mcause`  out  32  mcause CSR, `{intr, 26'b0, code}`
- `mstatus_mie`  out  1  global interrupt enable
- `mstatus_mpie`  out  1  previous MIE

## Operation
- States:
  - IDLE
  - DRAIN
  - COMMIT
  - REDIRECT
  - RET_REDIRECT
- **IDLE**
  - Priority: `exception` > `interrupt` > `mret`. Exception with `mret` in the same cycle is a trap; `mret` is dropped.
  - Trap detection: latch `epc` into `epc_q` with bits [1:0] forced to 0, latch `int_code`, latch `is_intr = !exception`, load drain counter with `DRAIN_CYCLES`, go to DRAIN.
  - mret: `MIE<=MPIE`, `MPIE<=1`, go to RET_REDIRECT.
  - `csr_we` writes apply only in IDLE and only when no trap or mret is taken that cycle. mstatus writes touch bit 3 (MIE) and bit 7 (MPIE) only. mepc writes force bits [1:0] to 0.
- **DRAIN**
  - `flush`=1.
  - Counter decrements each cycle; when it reaches 1, go to COMMIT.
- **COMMIT** (one cycle)
  - `mepc<=epc_q`, `mcause<={is_intr,26'b0,code_q}`, `MPIE<=MIE`, `MIE<=0`.
  - `flush`=1.
  - Go to REDIRECT.
- **REDIRECT**
  - `redirect_valid`=1, `redirect_pc=handler_pc`, sampled combinationally. Decode sees the new `mcause` this cycle, so the vectored address is correct.
  - `redirect_pc` is held stable while `!redirect_ready`.
  - On `redirect_ready`, go to IDLE.
- **RET_REDIRECT**
  - `redirect_valid`=1, `redirect_pc=mepc`.
  - `flush`=1 in the first cycle only.
  - On `redirect_ready`, go to IDLE.
- Inputs `interrupt`, `exception`, `mret` and `csr_we` are ignored in every state except IDLE.
- Reset mid-operation: all state returns to reset values immediately, and no commit occurs.

## Timing
- Reset values:
  - state=IDLE
  - `flush`=0, `redirect_valid`=0, `redirect_pc`=0, `trap_active`=0
  - `mepc`=`RESET_PC`, `mcause`=0
  - `mstatus_mie`=0, `mstatus_mpie`=0
- Trap detected at edge T (default `DRAIN_CYCLES`=2):
  - `flush` high for cycles T+1..T+3.
  - COMMIT occupies T+3.
  - CSRs are visible at T+4.
  - `redirect_valid` is high from T+4 until the ready cycle.
  - IDLE at the edge after ready.
- mret detected at T: `MIE`/`MPIE` update at T+1, and `redirect_valid` goes high at T+1.
- A new trap can be accepted in the first IDLE cycle after a redirect completes.
- `trap_active` is registered and equals `state != IDLE`.

## Structure
- `trap_pkg` holds:
  - the state enum `trap_state_e`
  - `CSR_SEL_MSTATUS`/`MEPC`/`MCAUSE` encodings
  - `MSTATUS_MIE_BIT`=3 and `MSTATUS_MPIE_BIT`=7
  - the mcause field widths
- Single module; the drain counter stays inline, with no sub-module.

## Test plan
- **Exception:** MIE=1, `exception=1`, `int_code=2`, `epc=32'h100` at T → `flush` high T+1..T+3; at T+4 `mcause=32'h2`, `mepc=32'h100`, MIE=0, MPIE=1; `redirect_pc=handler_pc`.
- **Interrupt, vectored:** `interrupt=1`, `int_code=7`, `epc=32'h203`, with decode computing vectored `handler_pc` from the fed-back `mcause` → `mcause=32'h8000_0007` and `mepc=32'h200`; `redirect_pc` at T+4 reflects `mcause`=7.
- **Simultaneous events:** `exception`, `interrupt` and `mret` all high → exception trap taken; `mcause[31]=0`; mret ignored.
- **mret:** MPIE=1, MIE=0, `mepc=32'h100`, `mret=1` → at T+1 MIE=1, MPIE=1, `redirect_valid=1`, `redirect_pc=32'h100`.
- **Backpressure and ignored writes:** hold `redirect_ready=0` for 5 cycles in REDIRECT → `redirect_valid` and `redirect_pc` stable; a `csr_we` to mepc in that window has no effect.
- **Reset mid-trap:** drop `rst_n` during DRAIN → all outputs at reset values immediately; `mcause` unchanged from 0.
